div_job_scheduler: RTL and testbench

Sequencing and arbitration front-end for the serial divider core. Two requesters, e.g. the Wishbone register slice and the LA/IO debug path, submit divide jobs. A round-robin arbiter grants one job at a time, and the block launches the divider with a one-cycle start pulse and waits for its finish pulse. It then returns quotient and remainder to the owning requester over a valid/ready response channel. Divide-by-zero is resolved locally without occupying the divider.

---
 rtl/div_job_scheduler.sv | 173 +++++++++++++++++
 tb/tb_div_job_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_job_scheduler.sv
// div_job_scheduler
//   Front-end for the serial divider core. Two requesters submit divide jobs;
//   a round-robin arbiter accepts one at a time, launches the divider with a
//   one-cycle start pulse, waits for the finish pulse, and returns quotient /
//   remainder to the owning requester over a valid/ready channel.
//   Divide-by-zero is answered locally (quotient all ones, remainder =
//   dividend) without starting the divider.
//
//   Optional feature macro: DIV_SCHED_WATCHDOG_EN
//     When defined, a BUSY-cycle counter aborts a job that has not finished
//     after WDOG_CYCLES cycles (div_abort_o pulse, rsp_err_o=1, zero result).
//     When undefined, BUSY waits indefinitely and div_abort_o/rsp_err_o are 0.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   per-requester job handshake (2 bits)
//   req_dividend_i/divisor_i  requester n operands in [n*XLEN +: XLEN]
//   rsp_valid_o/rsp_ready_i   per-requester response handshake (2 bits)
//   rsp_quotient_o/remainder  shared result bus, held during response
//   rsp_dbz_o, rsp_err_o      divide-by-zero / watchdog-abort flags
//   div_start_o, div_*_o      divider launch pulse and registered operands
//   div_fini_i, div_*_i       divider done pulse and its results
//   div_abort_o               one-cycle watchdog abort to the divider
//   busy_o                    registered, high whenever a job is in flight
module div_job_scheduler #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned WDOG_CYCLES = 80
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [2*XLEN-1:0] req_dividend_i,
  input  logic [2*XLEN-1:0] req_divisor_i,
  output logic [1:0]        rsp_valid_o,
  input  logic [1:0]        rsp_ready_i,
  output logic [XLEN-1:0]   rsp_quotient_o,
  output logic [XLEN-1:0]   rsp_remainder_o,
  output logic              rsp_dbz_o,
  output logic              rsp_err_o,
  output logic              div_start_o,
  output logic [XLEN-1:0]   div_dividend_o,
  output logic [XLEN-1:0]   div_divisor_o,
  input  logic              div_fini_i,
  input  logic [XLEN-1:0]   div_quotient_i,
  input  logic [XLEN-1:0]   div_remainder_i,
  output logic              div_abort_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            owner;
  logic            grant;
  logic            grant_vld;
  logic            accept;
  logic [XLEN-1:0] sel_dividend;
  logic [XLEN-1:0] sel_divisor;
  logic            wdog_expire;

  if (WDOG_CYCLES == 0) begin : g_bad_wdog
    $error("div_job_scheduler: WDOG_CYCLES must be at least 1");
  end

  // Round-robin: on contention the requester not served last wins.
  always_comb begin
    grant_vld = |req_valid_i;
    if (&req_valid_i) grant = ~last_grant;
    else              grant = req_valid_i[1];
  end

  always_comb begin
    sel_dividend = grant ? req_dividend_i[XLEN +: XLEN] : req_dividend_i[0 +: XLEN];
    sel_divisor  = grant ? req_divisor_i[XLEN +: XLEN]  : req_divisor_i[0 +: XLEN];
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && grant_vld && !reset_i) req_ready_o[grant] = 1'b1;
  end

  assign accept = (state == IDLE) && grant_vld;

`ifdef DIV_SCHED_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // Counter holds the number of BUSY cycles already completed, so it
  // expires in the WDOG_CYCLES-th BUSY cycle; a finish in that cycle wins.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)               wdog_cnt <= '0;
    else if (state == ISSUE)   wdog_cnt <= '0;
    else if (state == BUSY)    wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_expire = (state == BUSY) && !div_fini_i &&
                       (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  assign div_abort_o = wdog_expire;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    div_start_o = 1'b0;
    rsp_valid_o = '0;
    case (state)
      IDLE:  if (accept) state_nxt = (sel_divisor == '0) ? RESP : ISSUE;
      ISSUE: begin
        div_start_o = 1'b1;
        state_nxt   = BUSY;
      end
      BUSY:  if (div_fini_i || wdog_expire) state_nxt = RESP;
      RESP: begin
        rsp_valid_o[owner] = 1'b1;
        if (rsp_ready_i[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      busy_o          <= 1'b0;
      div_dividend_o  <= '0;
      div_divisor_o   <= '0;
      rsp_quotient_o  <= '0;
      rsp_remainder_o <= '0;
      rsp_dbz_o       <= 1'b0;
      rsp_err_o       <= 1'b0;
    end else begin
      busy_o <= (state_nxt != IDLE);
      case (state)
        IDLE: if (accept) begin
          owner          <= grant;
          last_grant     <= grant;
          div_dividend_o <= sel_dividend;
          div_divisor_o  <= sel_divisor;
          rsp_err_o      <= 1'b0;
          rsp_dbz_o      <= (sel_divisor == '0);
          if (sel_divisor == '0) begin
            rsp_quotient_o  <= '1;
            rsp_remainder_o <= sel_dividend;
          end
        end
        BUSY: if (div_fini_i) begin
          rsp_quotient_o  <= div_quotient_i;
          rsp_remainder_o <= div_remainder_i;
          rsp_dbz_o       <= 1'b0;
          rsp_err_o       <= 1'b0;
        end else if (wdog_expire) begin
          rsp_quotient_o  <= '0;
          rsp_remainder_o <= '0;
          rsp_dbz_o       <= 1'b0;
          rsp_err_o       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_job_scheduler.sv
// Self-checking bench for div_job_scheduler: a timing-level job model checks
// every output on every falling edge; directed scenarios add literal checks.
module tb_div_job_scheduler;
  localparam int XLEN = 32;
  localparam int WDOG = 80;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [1:0]        req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [2*XLEN-1:0] req_dividend_i, req_divisor_i;
  logic [XLEN-1:0]   rsp_quotient_o, rsp_remainder_o;
  logic              rsp_dbz_o, rsp_err_o, div_start_o, div_fini_i, div_abort_o, busy_o;
  logic [XLEN-1:0]   div_dividend_o, div_divisor_o, div_quotient_i, div_remainder_i;

  div_job_scheduler #(.XLEN(XLEN), .WDOG_CYCLES(WDOG)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_quotient_o(rsp_quotient_o), .rsp_remainder_o(rsp_remainder_o),
    .rsp_dbz_o(rsp_dbz_o), .rsp_err_o(rsp_err_o),
    .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_fini_i(div_fini_i), .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
    .div_abort_o(div_abort_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // requester queues: {dividend, divisor}
  logic [63:0] rq0[$], rq1[$];
  logic [1:0]  hs = '0;

  // divider emulation
  int          dcnt = 0, dlat = 3;
  bit          dhang = 1'b0;
  logic [31:0] da, db;

  // model state (job lifecycle expressed in cycle numbers)
  bit          m_have = 0, m_last = 1, m_own = 0, m_dbz = 0, m_err = 0;
  int          m_acc = 0, m_done = -1;
  logic [31:0] m_q, m_r;

  // observation records for literal checks
  int          n_start = 0, n_abort = 0, start_cyc = 0, abort_cyc = 0;
  int          hs_cyc = 0, rsp_first_cyc = 0;
  logic [1:0]  prev_rv = '0;
  int          log_own[$], log_dbz[$], log_err[$];
  logic [31:0] log_q[$], log_r[$];

  // stimulus driver: requesters hold valid until handshake; divider model
  initial begin
    req_valid_i = '0; req_dividend_i = '0; req_divisor_i = '0;
    div_fini_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
    forever begin
      @(posedge clk); #1;
      if (hs[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (hs[1] && rq1.size() > 0) void'(rq1.pop_front());
      req_valid_i[0] = (rq0.size() > 0);
      req_valid_i[1] = (rq1.size() > 0);
      req_dividend_i[31:0]  = (rq0.size() > 0) ? rq0[0][63:32] : 32'h0;
      req_divisor_i[31:0]   = (rq0.size() > 0) ? rq0[0][31:0]  : 32'h0;
      req_dividend_i[63:32] = (rq1.size() > 0) ? rq1[0][63:32] : 32'h0;
      req_divisor_i[63:32]  = (rq1.size() > 0) ? rq1[0][31:0]  : 32'h0;
      div_fini_i = 1'b0;
      div_quotient_i = $urandom;
      div_remainder_i = $urandom;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_fini_i = 1'b1;
          div_quotient_i = da / db;
          div_remainder_i = da % db;
        end
      end
    end
  end

  // compare process + model
  always @(negedge clk) begin
    logic [1:0]  exp_ready, v;
    logic [31:0] a, b;
    bit          g, in_rsp, exp_start, wd_fire;
    cyc++;
    if (reset_i) begin
      chk("reset_outputs", {req_ready_o, rsp_valid_o, rsp_quotient_o, rsp_remainder_o, rsp_dbz_o,
          rsp_err_o, div_start_o, div_dividend_o, div_divisor_o, div_abort_o, busy_o}, '0);
      m_have = 0; m_last = 1; m_done = -1; hs = '0; prev_rv = '0;
    end else begin
      v = req_valid_i;
      g = (v == 2'b11) ? !m_last : (v == 2'b10);
      exp_ready = '0;
      if (!m_have && v != 2'b00) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready_o, exp_ready);
      chk("busy", busy_o, m_have);
      exp_start = m_have && !m_dbz && (cyc == m_acc + 1);
      chk("div_start", div_start_o, exp_start);
      in_rsp = m_have && (m_done >= 0) && (cyc >= m_done);
      chk("rsp_valid", rsp_valid_o, in_rsp ? (m_own ? 2'b10 : 2'b01) : 2'b00);
      if (in_rsp) begin
        chk("rsp_quotient", rsp_quotient_o, m_q);
        chk("rsp_remainder", rsp_remainder_o, m_r);
        chk("rsp_dbz", rsp_dbz_o, m_dbz);
        chk("rsp_err", rsp_err_o, m_err);
      end
`ifdef DIV_SCHED_WATCHDOG_EN
      wd_fire = m_have && !m_dbz && (m_done < 0) && (cyc == m_acc + 1 + WDOG) && !div_fini_i;
`else
      wd_fire = 0;
`endif
      chk("div_abort", div_abort_o, wd_fire);

      // observations
      if (div_start_o) begin
        n_start++; start_cyc = cyc;
        if (!dhang) dcnt = dlat;
        da = div_dividend_o; db = div_divisor_o;
      end
      if (div_abort_o) begin n_abort++; abort_cyc = cyc; end
      if (rsp_valid_o != 2'b00 && prev_rv == 2'b00) rsp_first_cyc = cyc;
      prev_rv = rsp_valid_o;
      if ((rsp_valid_o & rsp_ready_i) != 2'b00) begin
        log_own.push_back(rsp_valid_o[1] ? 1 : 0);
        log_q.push_back(rsp_quotient_o); log_r.push_back(rsp_remainder_o);
        log_dbz.push_back(int'(rsp_dbz_o)); log_err.push_back(int'(rsp_err_o));
      end
      hs = req_valid_i & req_ready_o;
      if (hs != 2'b00) hs_cyc = cyc;

      // model update
      if (!m_have) begin
        if (v != 2'b00) begin
          a = g ? req_dividend_i[63:32] : req_dividend_i[31:0];
          b = g ? req_divisor_i[63:32]  : req_divisor_i[31:0];
          m_have = 1; m_own = g; m_last = g; m_acc = cyc; m_err = 0;
          m_dbz = (b == 0);
          if (b == 0) begin m_q = 32'hFFFF_FFFF; m_r = a; m_done = cyc + 1; end
          else begin m_q = a / b; m_r = a % b; m_done = -1; end
        end
      end else if (!m_dbz && m_done < 0 && cyc >= m_acc + 2 && div_fini_i) begin
        m_done = cyc + 1;
      end else if (wd_fire) begin
        m_done = cyc + 1; m_q = 0; m_r = 0; m_err = 1;
      end else if (in_rsp && rsp_ready_i[m_own]) begin
        m_have = 0;
      end
    end
  end

  task automatic wait_done(input string nm, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk); #1;
      if (rq0.size() == 0 && rq1.size() == 0 && !m_have) ok = 1;
    end
    chk({nm, "_completed"}, ok, 1'b1);
  endtask

  task automatic set_inputs(input logic rst, input logic [1:0] rr);
    @(posedge clk); #2;
    reset_i = rst; rsp_ready_i = rr;
  endtask

  initial begin
    int n0, base, cnt;
    bit ok;
    logic [31:0] q_hold;
    reset_i = 1'b1; rsp_ready_i = 2'b11;
    repeat (3) @(posedge clk);
    set_inputs(1'b0, 2'b11);

    // 1: single job 100/7, 33-cycle divider
    dlat = 33;
    rq0.push_back({32'd100, 32'd7});
    wait_done("t1", 100);
    chk("t1_start_lat", start_cyc - hs_cyc, 1);
    chk("t1_rsp_lat", rsp_first_cyc - hs_cyc, 35);
    chk("t1_quotient", log_q[0], 14);
    chk("t1_remainder", log_r[0], 2);
    chk("t1_owner", log_own[0], 0);

    // 2: both requesters contend; last grant was 0 so order is 1,0,1,0
    dlat = 3;
    rq0.push_back({32'd50, 32'd5}); rq0.push_back({32'd50, 32'd5});
    rq1.push_back({32'd9, 32'd4});  rq1.push_back({32'd9, 32'd4});
    wait_done("t2", 200);
    chk("t2_owners", {log_own[1][1:0], log_own[2][1:0], log_own[3][1:0], log_own[4][1:0]}, 8'b01_00_01_00);
    chk("t2_res_r1", {log_q[1], log_r[1]}, {32'd2, 32'd1});
    chk("t2_res_r0", {log_q[2], log_r[2]}, {32'd10, 32'd0});

    // 3: divide by zero from requester 1
    n0 = n_start;
    rq1.push_back({32'h1234, 32'd0});
    wait_done("t3", 20);
    chk("t3_rsp_lat", rsp_first_cyc - hs_cyc, 1);
    chk("t3_no_start", n_start - n0, 0);
    chk("t3_result", {log_own[5][0], log_q[5], log_r[5], log_dbz[5][0]}, {1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1});

    // 4: response back-pressure on requester 0 while requester 1 waits
    set_inputs(1'b0, 2'b10);
    rq0.push_back({32'd77, 32'd3}); rq1.push_back({32'd5, 32'd2});
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); #1; ok = (rsp_valid_o == 2'b01); end
    chk("t4_rsp_seen", ok, 1'b1);
    q_hold = rsp_quotient_o; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (req_ready_o != 2'b00 || rsp_valid_o != 2'b01 || rsp_quotient_o != q_hold) cnt++;
    end
    chk("t4_hold_stable", cnt, 0);
    chk("t4_hold_result", {rsp_quotient_o, rsp_remainder_o}, {32'd25, 32'd2});
    set_inputs(1'b0, 2'b11);
    wait_done("t4", 50);
    chk("t4_second", {log_own[7][0], log_q[7], log_r[7]}, {1'b1, 32'd2, 32'd1});

    // 5: reset while BUSY; stale finish must be ignored
    dlat = 20; n0 = n_start;
    rq0.push_back({32'd1000, 32'd10});
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = (n_start != n0); end
    repeat (5) @(posedge clk);
    base = log_q.size();
    set_inputs(1'b1, 2'b11);
    set_inputs(1'b0, 2'b11);
    for (int i = 0; i < 40 && dcnt != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t5_no_response", log_q.size() - base, 0);
    dlat = 4;
    rq1.push_back({32'd81, 32'd9});
    wait_done("t5", 40);
    chk("t5_next_job", {log_own[base][0], log_q[base], log_r[base]}, {1'b1, 32'd9, 32'd0});

    // 6: divider never finishes
    dhang = 1'b1;
    base = log_q.size(); n0 = n_abort;
    rq0.push_back({32'd10, 32'd3});
`ifdef DIV_SCHED_WATCHDOG_EN
    wait_done("t6", 200);
    chk("t6_abort_once", n_abort - n0, 1);
    chk("t6_abort_cyc", abort_cyc - hs_cyc, 81);
    chk("t6_rsp_lat", rsp_first_cyc - hs_cyc, 82);
    chk("t6_result", {log_q[base], log_r[base], log_err[base][0]}, {32'd0, 32'd0, 1'b1});
`else
    repeat (150) @(negedge clk);
    #1;
    chk("t6_busy_hold", busy_o, 1'b1);
    chk("t6_no_abort", n_abort - n0, 0);
    set_inputs(1'b1, 2'b11);
    set_inputs(1'b0, 2'b11);
    repeat (2) @(negedge clk);
`endif
    dhang = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
